ifft_butterfly_pipe: RTL and testbench

- Pipelined radix-2 inverse butterfly for the IFFT datapath. It is the inverse-direction counterpart of the forward DIT butterfly.
- Decimation-in-frequency form with a conjugated twiddle:
  - X = (A + B) / 2^S
  - Y = (A − B) · conj(W) / 2^S
- Streams one butterfly per clock under a valid/ready handshake on both sides.
- Sits between the IFFT stage memory reader and the stage writer.

---
 rtl/ifft_butterfly_pipe.sv | 147 ++++++++++++++
 tb/tb_ifft_butterfly_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifft_butterfly_pipe.sv
// rtl/ifft_butterfly_pipe.sv - pipelined radix-2 DIF inverse butterfly with conjugated twiddle
module ifft_butterfly_pipe #(
    parameter int DW    = 16,
    parameter int TW    = 16,
    parameter int SCALE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] ar,
    input  logic [DW-1:0] ai,
    input  logic [DW-1:0] br,
    input  logic [DW-1:0] bi,
    input  logic [TW-1:0] wr,
    input  logic [TW-1:0] wi,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] xr,
    output logic [DW-1:0] xi,
    output logic [DW-1:0] yr,
    output logic [DW-1:0] yi
);

    // Product width: (DW+1)-bit difference times TW-bit twiddle, summed twice.
    localparam int PW    = DW + TW + 1;
    // Right-shift applied to X and to Y (Y also drops the Q1.(TW-1) fraction).
    localparam int KX    = (SCALE != 0) ? 1 : 0;
    localparam int KY    = TW - 1 + KX;
    // Half-LSB rounding bias; evaluates to 0 when no shift is applied.
    localparam int RND_X = (1 << KX) >> 1;
    localparam int RND_Y = (1 << KY) >> 1;

    localparam logic signed [DW-1:0] DMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] DMIN = {1'b1, {(DW-1){1'b0}}};

    // Clamp a wide signed value into the DW-bit output range.
    function automatic logic signed [DW-1:0] sat_dw(input logic signed [PW:0] v);
        if (v > (PW+1)'(DMAX)) begin
            return DMAX;
        end else if (v < (PW+1)'(DMIN)) begin
            return DMIN;
        end else begin
            return v[DW-1:0];
        end
    endfunction

    // Single global advance: every stage moves together or everything holds.
    logic en;

    // Stage 1 registers: sum/difference and the twiddle that travels with them.
    logic                 v1_q;
    logic signed [DW:0]   s1r_q, s1i_q, d1r_q, d1i_q;
    logic signed [TW-1:0] w1r_q, w1i_q;
    logic signed [DW:0]   s1r_d, s1i_d, d1r_d, d1i_d;

    // Stage 2 registers: forwarded sum and full-precision conjugate product.
    logic                 v2_q;
    logic signed [DW:0]   s2r_q, s2i_q;
    logic signed [PW-1:0] p2r_q, p2i_q;
    logic signed [PW-1:0] p2r_d, p2i_d;

    // Stage 3 (output) registers.
    logic                 v3_q;
    logic signed [DW-1:0] xr_q, xi_q, yr_q, yi_q;
    logic signed [DW-1:0] xr_d, xi_d, yr_d, yi_d;

    // Rounded/shifted intermediates ahead of saturation.
    logic signed [PW:0]   xr_rnd, xi_rnd, yr_rnd, yi_rnd;

    assign en       = !v3_q || out_ready;
    assign in_ready = en;

    // Stage 1 arithmetic: sign-extended sum and difference of A and B.
    always_comb begin
        s1r_d = $signed({ar[DW-1], ar}) + $signed({br[DW-1], br});
        s1i_d = $signed({ai[DW-1], ai}) + $signed({bi[DW-1], bi});
        d1r_d = $signed({ar[DW-1], ar}) - $signed({br[DW-1], br});
        d1i_d = $signed({ai[DW-1], ai}) - $signed({bi[DW-1], bi});
    end

    // Stage 2 arithmetic: (dr + j di) * (wr - j wi), kept at full precision.
    always_comb begin
        p2r_d = PW'(d1r_q) * PW'(w1r_q) + PW'(d1i_q) * PW'(w1i_q);
        p2i_d = PW'(d1i_q) * PW'(w1r_q) - PW'(d1r_q) * PW'(w1i_q);
    end

    // Stage 3 arithmetic: round-half-up via bias plus arithmetic shift, then clamp.
    always_comb begin
        xr_rnd = ((PW+1)'(s2r_q) + (PW+1)'(RND_X)) >>> KX;
        xi_rnd = ((PW+1)'(s2i_q) + (PW+1)'(RND_X)) >>> KX;
        yr_rnd = ((PW+1)'(p2r_q) + (PW+1)'(RND_Y)) >>> KY;
        yi_rnd = ((PW+1)'(p2i_q) + (PW+1)'(RND_Y)) >>> KY;
        xr_d   = sat_dw(xr_rnd);
        xi_d   = sat_dw(xi_rnd);
        yr_d   = sat_dw(yr_rnd);
        yi_d   = sat_dw(yi_rnd);
    end

    // Pipeline registers: clear on reset, shift all stages together when en is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            s1r_q <= '0;
            s1i_q <= '0;
            d1r_q <= '0;
            d1i_q <= '0;
            w1r_q <= '0;
            w1i_q <= '0;
            v2_q  <= 1'b0;
            s2r_q <= '0;
            s2i_q <= '0;
            p2r_q <= '0;
            p2i_q <= '0;
            v3_q  <= 1'b0;
            xr_q  <= '0;
            xi_q  <= '0;
            yr_q  <= '0;
            yi_q  <= '0;
        end else if (en) begin
            v1_q  <= in_valid;
            s1r_q <= s1r_d;
            s1i_q <= s1i_d;
            d1r_q <= d1r_d;
            d1i_q <= d1i_d;
            w1r_q <= $signed(wr);
            w1i_q <= $signed(wi);
            v2_q  <= v1_q;
            s2r_q <= s1r_q;
            s2i_q <= s1i_q;
            p2r_q <= p2r_d;
            p2i_q <= p2i_d;
            v3_q  <= v2_q;
            xr_q  <= xr_d;
            xi_q  <= xi_d;
            yr_q  <= yr_d;
            yi_q  <= yi_d;
        end
    end

    assign out_valid = v3_q;
    assign xr        = xr_q;
    assign xi        = xi_q;
    assign yr        = yr_q;
    assign yi        = yi_q;

endmodule

// File: tb/tb_ifft_butterfly_pipe.sv
// tb/tb_ifft_butterfly_pipe.sv - scoreboard bench for ifft_butterfly_pipe (SCALE=1 and SCALE=0)
module tb_ifft_butterfly_pipe;

    typedef struct {
        longint x_r;
        longint x_i;
        longint y_r;
        longint y_i;
        int     edge_in;
        bit     lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] ar, ai, br, bi, wr, wi;
    logic        in_ready1, out_valid1, in_ready0, out_valid0;
    logic [15:0] xr1, xi1, yr1, yi1, xr0, xi0, yr0, yi0;

    int   n_vec  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    bit   lat_mode = 1'b0;
    exp_t sb1[$];
    exp_t sb0[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ifft_butterfly_pipe #(.DW(16), .TW(16), .SCALE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .ar(ar), .ai(ai), .br(br), .bi(bi), .wr(wr), .wi(wi),
        .out_valid(out_valid1), .out_ready(out_ready),
        .xr(xr1), .xi(xi1), .yr(yr1), .yi(yi1)
    );

    ifft_butterfly_pipe #(.DW(16), .TW(16), .SCALE(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .ar(ar), .ai(ai), .br(br), .bi(bi), .wr(wr), .wi(wi),
        .out_valid(out_valid0), .out_ready(out_ready),
        .xr(xr0), .xi(xi0), .yr(yr0), .yi(yi0)
    );

    // Reference arithmetic: exact complex math, round half up, clamp to 16 bits.
    function automatic longint rnd(longint v, int k);
        if (k == 0) return v;
        return (v + (longint'(1) <<< (k - 1))) >>> k;
    endfunction

    function automatic longint sat16(longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic exp_t model(longint a_r, longint a_i, longint b_r, longint b_i,
                                   longint w_r, longint w_i, int s, int ed, bit lat);
        exp_t   e;
        longint d_r = a_r - b_r;
        longint d_i = a_i - b_i;
        // (A - B) * conj(W) = (d_r + j d_i)(w_r - j w_i)
        e.x_r     = sat16(rnd(a_r + b_r, s));
        e.x_i     = sat16(rnd(a_i + b_i, s));
        e.y_r     = sat16(rnd(d_r * w_r + d_i * w_i, 15 + s));
        e.y_i     = sat16(rnd(d_i * w_r - d_r * w_i, 15 + s));
        e.edge_in = ed;
        e.lat     = lat;
        return e;
    endfunction

    task automatic chk(string name, longint act, longint exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cmp_out(string tag, exp_t e, logic [15:0] r0, logic [15:0] r1,
                           logic [15:0] r2, logic [15:0] r3);
        chk({tag, "_xr"}, longint'($signed(r0)), e.x_r);
        chk({tag, "_xi"}, longint'($signed(r1)), e.x_i);
        chk({tag, "_yr"}, longint'($signed(r2)), e.y_r);
        chk({tag, "_yi"}, longint'($signed(r3)), e.y_i);
    endtask

    // Stimulus side of the scoreboard: push expectations for every accepted input.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready1)
            sb1.push_back(model($signed(ar), $signed(ai), $signed(br), $signed(bi),
                                $signed(wr), $signed(wi), 1, cyc + 1, lat_mode));
        if (!rst && in_valid && in_ready0)
            sb0.push_back(model($signed(ar), $signed(ai), $signed(br), $signed(bi),
                                $signed(wr), $signed(wi), 0, cyc + 1, lat_mode));
    end

    // Monitor for the scaled instance: compare whenever valid, pop on consume.
    always @(negedge clk) begin
        if (rst) begin
            sb1.delete();
        end else if (out_valid1) begin
            if (sb1.size() == 0) begin
                chk("s1_spurious_out", 1, 0);
            end else begin
                cmp_out("s1", sb1[0], xr1, xi1, yr1, yi1);
                if (out_ready) begin
                    if (sb1[0].lat) chk("s1_latency", cyc + 1 - sb1[0].edge_in, 3);
                    void'(sb1.pop_front());
                end
            end
        end
    end

    // Monitor for the unscaled instance.
    always @(negedge clk) begin
        if (rst) begin
            sb0.delete();
        end else if (out_valid0) begin
            if (sb0.size() == 0) begin
                chk("s0_spurious_out", 1, 0);
            end else begin
                cmp_out("s0", sb0[0], xr0, xi0, yr0, yi0);
                if (out_ready) begin
                    if (sb0[0].lat) chk("s0_latency", cyc + 1 - sb0[0].edge_in, 3);
                    void'(sb0.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(int a_r, int a_i, int b_r, int b_i, int w_r, int w_i);
        ar = 16'(a_r); ai = 16'(a_i); br = 16'(b_r);
        bi = 16'(b_i); wr = 16'(w_r); wi = 16'(w_i);
    endtask

    function automatic logic [15:0] pick();
        int sel = int'($urandom_range(0, 9));
        if (sel == 0) return 16'h7fff;
        if (sel == 1) return 16'h8000;
        return 16'($urandom);
    endfunction

    task automatic rand_in();
        ar = pick(); ai = pick(); br = pick(); bi = pick(); wr = pick(); wi = pick();
    endtask

    task automatic send(int a_r, int a_i, int b_r, int b_i, int w_r, int w_i);
        set_in(a_r, a_i, b_r, b_i, w_r, w_i);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (sb1.size() == 0 && sb0.size() == 0) break;
            tick();
        end
        chk("drain_left", sb1.size() + sb0.size(), 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid1", out_valid1, 0);
        chk("rst_out_valid0", out_valid0, 0);
        chk("rst_in_ready", in_ready1, 1);
        chk("rst_xr", xr1, 0);
        chk("rst_yi", yi1, 0);
        tick();

        // Directed vectors with latency checked.
        lat_mode = 1'b1;
        send(100, 0, 50, 0, 16384, 0);
        drain();
        send(0, 0, 0, -1000, 0, 16384);
        drain();
        send(32767, 0, 32767, 0, 0, 0);
        send(-32768, 0, -32768, 0, 0, 0);
        send(-32768, -32768, 32767, 32767, -32768, -32768);
        drain();

        // Eight back-to-back inputs; latency 3 on each implies no gaps.
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_in();
            @(negedge clk);
            chk("stream_in_ready", in_ready1, 1);
            tick();
        end
        drain();

        // Backpressure: stall as soon as the first result appears.
        lat_mode  = 1'b0;
        in_valid  = 1'b1;
        rand_in();
        begin
            int guard = 0;
            while (!out_valid1 && guard < 20) begin
                tick();
                rand_in();
                guard++;
            end
            chk("bp_first_valid_seen", out_valid1, 1);
        end
        out_ready = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready1, 0);
            chk("bp_out_valid", out_valid1, 1);
            tick();
            rand_in();
        end
        out_ready = 1'b1;
        repeat (10) begin
            tick();
            rand_in();
        end
        drain();

        // Reset with three results in flight.
        in_valid = 1'b1;
        repeat (3) begin
            rand_in();
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_out_valid", out_valid1, 0);
        chk("mrst_xr", xr1, 0);
        chk("mrst_xi", xi1, 0);
        chk("mrst_yr", yr1, 0);
        chk("mrst_yi", yi1, 0);
        tick();
        lat_mode = 1'b1;
        send(1234, -567, -890, 4321, 23170, -23170);
        drain();

        // Random traffic with random backpressure and bubbles.
        lat_mode = 1'b0;
        repeat (400) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            rand_in();
            tick();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
